// File: rtl/arith_pkg.sv
// Shared opcodes and default width for the shared-arithmetic scheduler.
package arith_pkg;

  localparam int unsigned DW_DEFAULT = 16;

  typedef enum logic [1:0] {
    OP_MUL = 2'b00,
    OP_ADD = 2'b01,
    OP_SUB = 2'b10,
    OP_MAC = 2'b11
  } op_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; last_grant moves only when a grant is consumed.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (advance) begin
      last_grant <= grant[1];
    end
  end

  // On contention the requester that did not win last time is favoured.
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/arith_arbiter.sv
// Two requesters sharing one multiplier and one adder/subtractor via a 2-stage pipeline.
import arith_pkg::*;

module arith_arbiter #(
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  input  logic [1:0]      req0_op,
  input  logic [DW-1:0]   req0_a,
  input  logic [DW-1:0]   req0_b,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [1:0]      req1_op,
  input  logic [DW-1:0]   req1_a,
  input  logic [DW-1:0]   req1_b,
  output logic            req1_ready,
  output logic            rsp_valid,
  output logic            rsp_id,
  output logic [2*DW-1:0] rsp_data,
  input  logic            rsp_ready
);

  localparam int unsigned RW = 2 * DW;

  logic          s1_valid;
  logic          s1_id;
  op_t           s1_op;
  logic [DW-1:0] s1_a;
  logic [DW-1:0] s1_b;
  logic [RW-1:0] acc0;
  logic [RW-1:0] acc1;

  logic [1:0]    grant;
  logic          s2_load;
  logic          s1_can_accept;
  logic          accept;
  logic [RW-1:0] prod;
  logic [RW-1:0] acc_cur;
  logic [RW-1:0] mac_sum;
  logic [RW-1:0] result;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   ({req1_valid, req0_valid}),
    .advance (accept),
    .grant   (grant)
  );

  // S2 drains on consume or when empty; S1 frees up when it moves along.
  assign s2_load       = !rsp_valid || rsp_ready;
  assign s1_can_accept = !s1_valid || s2_load;
  assign accept        = s1_can_accept && (grant != 2'b00) && !rst;
  assign req0_ready    = grant[0] && s1_can_accept && !rst;
  assign req1_ready    = grant[1] && s1_can_accept && !rst;

  // Single shared multiplier feeds both MUL and MAC.
  always_comb begin
    prod    = RW'(s1_a) * RW'(s1_b);
    acc_cur = s1_id ? acc1 : acc0;
    mac_sum = acc_cur + prod;
    result  = '0;
    case (s1_op)
      OP_MUL: result = prod;
      OP_ADD: result = RW'(s1_a) + RW'(s1_b);
      OP_SUB: result = RW'(s1_a) - RW'(s1_b);
      OP_MAC: result = mac_sum;
      default: result = prod;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      acc0      <= '0;
      acc1      <= '0;
    end else begin
      if (s2_load) begin
        rsp_valid <= s1_valid;
        if (s1_valid) begin
          rsp_id   <= s1_id;
          rsp_data <= result;
          if (s1_op == OP_MAC) begin
            if (s1_id) acc1 <= mac_sum;
            else       acc0 <= mac_sum;
          end
        end
      end
      if (s1_can_accept) begin
        s1_valid <= accept;
      end
    end
  end

  // Operand capture needs no reset: it is qualified by s1_valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_id <= grant[1];
      s1_op <= grant[1] ? op_t'(req1_op) : op_t'(req0_op);
      s1_a  <= grant[1] ? req1_a : req0_a;
      s1_b  <= grant[1] ? req1_b : req0_b;
    end
  end

endmodule

// File: tb/tb_arith_arbiter.sv
// Directed bench for arith_arbiter with hand-computed expected values.
`timescale 1ns/1ps
module tb_arith_arbiter;
  import arith_pkg::*;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [1:0]  req0_op, req1_op;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic        rsp_valid, rsp_id, rsp_ready;
  logic [31:0] rsp_data;

  int passed = 0;
  int total  = 0;

  arith_arbiter #(.DW(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // One isolated request: ready now, nothing at k+1, result at k+2.
  task automatic single(input bit id, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp, input string tag);
    if (id) begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    #1;
    check({tag, "_ready"}, 32'(id ? req1_ready : req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check({tag, "_k1_valid"}, 32'(rsp_valid), 32'd0);
    tick();
    check({tag, "_k2_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_id"}, 32'(rsp_id), 32'(id));
    check({tag, "_data"}, rsp_data, exp);
  endtask

  initial begin
    int n0, n1, acnt, rcnt, first_rsp, last_rsp, n, r;
    logic [31:0] exp_d;
    rst = 1'b1;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = OP_MUL; req0_a = '0; req0_b = '0;
    req1_valid = 1'b1; req1_op = OP_MUL; req1_a = '0; req1_b = '0;

    // Reset state, with requests pending
    tick();
    tick();
    check("rst_req0_ready", 32'(req0_ready), 32'd0);
    check("rst_req1_ready", 32'(req1_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;

    // Single-op arithmetic and latency
    single(1'b0, OP_MUL, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, "mul_max");
    single(1'b0, OP_ADD, 16'hFFFF, 16'hFFFF, 32'h0001FFFE, "add_max");
    single(1'b1, OP_SUB, 16'd3, 16'd5, 32'hFFFFFFFE, "sub_wrap");
    single(1'b1, OP_SUB, 16'd5, 16'd3, 32'h00000002, "sub_pos");
    tick();

    // Round-robin with both requesters continuously valid
    do_reset();
    n0 = 0; n1 = 0; acnt = 0; rcnt = 0; first_rsp = -1; last_rsp = -1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      req0_valid = (n0 < 4); req0_op = OP_ADD; req0_a = 16'(n0); req0_b = 16'h0100;
      req1_valid = (n1 < 4); req1_op = OP_ADD; req1_a = 16'(n1); req1_b = 16'h0200;
      #1;
      if (req0_valid && req0_ready) begin
        check("rr_accept_order", 32'd0, 32'(acnt % 2)); acnt++; n0++;
      end
      if (req1_valid && req1_ready) begin
        check("rr_accept_order", 32'd1, 32'(acnt % 2)); acnt++; n1++;
      end
      if (rsp_valid) begin
        check("rr_rsp_id", 32'(rsp_id), 32'(rcnt % 2));
        exp_d = 32'(rcnt / 2) + ((rcnt % 2 == 1) ? 32'h0200 : 32'h0100);
        check("rr_rsp_data", rsp_data, exp_d);
        if (first_rsp < 0) first_rsp = cyc;
        last_rsp = cyc;
        rcnt++;
      end
      tick();
    end
    check("rr_accepted", 32'(acnt), 32'd8);
    check("rr_responses", 32'(rcnt), 32'd8);
    check("rr_back_to_back", 32'(last_rsp - first_rsp), 32'd7);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Interleaved MACs per requester accumulator
    single(1'b0, OP_MAC, 16'd3, 16'd4, 32'd12, "mac0_a");
    single(1'b1, OP_MAC, 16'd2, 16'd2, 32'd4, "mac1_a");
    single(1'b0, OP_MAC, 16'd5, 16'd6, 32'd42, "mac0_b");
    tick();

    // Stream of 6 with a 5-cycle backpressure window
    n = 0; r = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      rsp_ready = !(cyc >= 3 && cyc < 8);
      req0_valid = (n < 6); req0_op = OP_ADD; req0_a = 16'(n + 1); req0_b = 16'h1000;
      #1;
      if (cyc >= 3 && cyc < 8) check("bp_ready_low", 32'(req0_ready), 32'd0);
      if (cyc == 8) check("bp_no_bubble", 32'(req0_ready), 32'd1);
      if (rsp_valid) begin
        check("bp_rsp_id", 32'(rsp_id), 32'd0);
        check("bp_rsp_data", rsp_data, 32'(r + 1) + 32'h1000);
        if (rsp_ready) r++;
      end
      if (req0_valid && req0_ready) n++;
      tick();
    end
    check("bp_accepted", 32'(n), 32'd6);
    check("bp_received", 32'(r), 32'd6);
    req0_valid = 1'b0;
    rsp_ready = 1'b1;

    // Reset with two requests in flight, then accumulators must be clear
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 16'd1; req0_b = 16'd1;
    req1_valid = 1'b1; req1_op = OP_ADD; req1_a = 16'd2; req1_b = 16'd2;
    tick();
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rstf_ready0", 32'(req0_ready), 32'd0);
    tick();
    rst = 1'b0;
    check("rstf_rsp_valid", 32'(rsp_valid), 32'd0);
    req0_valid = 1'b1; req0_op = OP_MAC; req0_a = 16'd1; req0_b = 16'd1;
    req1_valid = 1'b1; req1_op = OP_MAC; req1_a = 16'd1; req1_b = 16'd1;
    #1;
    check("rstf_grant0", 32'(req0_ready), 32'd1);
    check("rstf_grant1", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0;
    #1;
    check("rstf_second1", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0;
    check("rstf_r0_valid", 32'(rsp_valid), 32'd1);
    check("rstf_r0_id", 32'(rsp_id), 32'd0);
    check("rstf_r0_data", rsp_data, 32'd1);
    tick();
    check("rstf_r1_valid", 32'(rsp_valid), 32'd1);
    check("rstf_r1_id", 32'(rsp_id), 32'd1);
    check("rstf_r1_data", rsp_data, 32'd1);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/arith_arbiter.md
# arith_arbiter

Shared-arithmetic scheduler: two requesters share one unsigned DW×DW multiplier and one 2·DW adder/subtractor through a round-robin arbiter and a 2-stage pipeline. Each request carries an opcode (MUL, ADD, SUB, MAC) and two operands. Each request returns one tagged 2·DW result over a valid/ready response port. It sits between the control FSMs that need arithmetic and the combinational mul/add/sub datapath, so no second multiplier has to be instantiated.

## Interface
- DW, 16, operand width; results are 2·DW wide.
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- req0_valid  in  1  requester 0 holds a request
- req0_op  in  2  opcode: 00 MUL, 01 ADD, 10 SUB, 11 MAC
- req0_a  in  DW  operand a, unsigned
- req0_b  in  DW  operand b, unsigned
- req0_ready  out  1  request 0 accepted this cycle when high with req0_valid
- req1_valid, req1_op, req1_a, req1_b, req1_ready: same as requester 0, for requester 1
- rsp_valid  out  1  result available
- rsp_id  out  1  requester that issued the result
- rsp_data  out  2·DW  result
- rsp_ready  in  1  consumer takes result this cycle

## Operation
- Ops, all modulo 2^(2·DW), operands zero-extended to 2·DW:
  - MUL = a*b
  - ADD = a+b
  - SUB = a−b, wraps two's-complement
  - MAC: acc[id] ← acc[id] + a*b, and the result is the new acc[id]
- acc0 and acc1 are per-requester 2·DW accumulators. Only MAC changes them.
- Pipeline:
  - S1 is an operand register holding valid, id, op, a and b.
  - S2 is a result register driving rsp_*.
  - Computation, including the accumulator update, happens on the S1→S2 transfer.
- Advance rules:
  - S2 loads when S2 is empty or rsp_ready=1.
  - S1 moves to S2 under the same condition.
  - S1 can accept a new request when S1 is empty or S1 moves this cycle.
- Arbitration:
  - last_grant register; reset value 1, so requester 0 wins first.
  - One valid requester: it is granted.
  - Both valid: the requester ≠ last_grant is granted.
  - reqN_ready = grant_N & S1-can-accept.
  - last_grant updates only on an accepted transfer.
- reqN_ready may depend combinationally on both valids and on rsp_ready. Requesters must not make valid depend on ready.
- Once asserted, a request holds op/a/b stable until accepted. Requests are never dropped.
- Responses leave in acceptance order. Back-to-back MACs from the same id see the previous MAC's accumulated value.
- Reset clears:
  - S1 and S2 valid bits
  - acc0 and acc1, to 0
  - last_grant, to 1
  - In-flight requests are discarded.

## Timing
- Reset values: rsp_valid=0, rsp_id=0, rsp_data=0. req0_ready and req1_ready are 0 while rst=1.
- Latency: a request accepted in cycle k shows rsp_valid=1 in cycle k+2, provided there is no backpressure.
- Throughput: 1 result per cycle while rsp_ready=1. At most 2 requests are in flight.
- Backpressure, when rsp_valid=1 and rsp_ready=0:
  - rsp_id and rsp_data are held stable.
  - S1 holds.
  - Both readies are 0 whenever S1 is full.
- A response taken with rsp_ready=1 in the same cycle S1 is full lets S1 advance and a new request be accepted in that cycle, with no bubble.
- rst has priority over every other event in the same cycle.

## Structure
- Shared package arith_pkg holds:
  - OP_MUL, OP_ADD, OP_SUB, OP_MAC opcode constants
  - the op_t 2-bit typedef
  - default DW
- Sub-module rr_arb2 is a 2-way round-robin arbiter with last_grant state.
  - Inputs: valid[1:0], advance.
  - Outputs: one-hot grant.
- The compute function is inlined in arith_arbiter. It uses a single multiplier shared by MUL and MAC.

## Test plan
- MUL req0 a=16'hFFFF, b=16'hFFFF, rsp_ready=1 → rsp_data=32'hFFFE0001, rsp_id=0, exactly 2 cycles after acceptance.
- ADD FFFF+FFFF → 32'h0001FFFE. SUB 3−5 → 32'hFFFFFFFE. SUB 5−3 → 32'h00000002.
- Both requesters valid continuously, 4 requests each, straight after reset → accept order 0,1,0,1,… and rsp_id sequence 0,1,0,1,0,1,0,1, one result per cycle.
- Interleaved MACs: req0 MAC(3,4), req1 MAC(2,2), req0 MAC(5,6) → results 12 (id0), 4 (id1), 42 (id0).
- Stream of 6 requests with rsp_ready held low 5 cycles mid-stream:
  - rsp_data and rsp_id stay stable.
  - Readies drop once S1 is full.
  - After release, all 6 results arrive in order, with no loss and no duplicates.
- rst pulsed 1 cycle with 2 requests in flight → next cycle rsp_valid=0. Then req1 MAC(1,1) and req0 MAC(1,1) offered together → req0 granted first, both results equal 1 (accumulators cleared).
